// File: rtl/cmp_window_stats.sv
// Window statistics collector for the 4-bit comparator stage: counts the results per window,
// re-checks every result against a local golden compare and emits one summary record per window.
module cmp_window_stats #(
  parameter int WIN = 8,
  parameter int CW  = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    a,
  input  logic [3:0]    b,
  input  logic          ans1,
  input  logic          ans2,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_samples,
  output logic [CW-1:0] out_ugt_cnt,
  output logic [CW-1:0] out_sgt_cnt,
  output logic [CW-1:0] out_mis_cnt,
  output logic          out_err,
  output logic          err_sticky
);

  typedef enum logic {COLLECT = 1'b0, REPORT = 1'b1} state_t;

  state_t        state_q, state_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic [CW-1:0] samples_q, samples_d;
  logic [CW-1:0] ugt_q, ugt_d;
  logic [CW-1:0] sgt_q, sgt_d;
  logic [CW-1:0] mis_q, mis_d;
  logic          win_err_q, win_err_d;
  logic          err_sticky_q, err_sticky_d;
  logic [CW-1:0] out_samples_q, out_samples_d;
  logic [CW-1:0] out_ugt_q, out_ugt_d;
  logic [CW-1:0] out_sgt_q, out_sgt_d;
  logic [CW-1:0] out_mis_q, out_mis_d;
  logic          out_err_q, out_err_d;

  logic          accept;
  logic          golden_u, golden_s, chk_err, close;
  logic [CW-1:0] samples_inc, ugt_inc, sgt_inc, mis_inc;

  // in_ready_q is only ever high in COLLECT, so it alone qualifies an accept.
  assign accept   = in_valid & in_ready_q;
  assign golden_u = a > b;
  assign golden_s = $signed({a[3], a}) > $signed({b[3], b});
  assign chk_err  = accept & ((ans1 != golden_u) | (ans2 != golden_s));

  assign samples_inc = samples_q + CW'(accept);
  assign ugt_inc     = ugt_q + CW'(accept & ans1);
  assign sgt_inc     = sgt_q + CW'(accept & ans2);
  assign mis_inc     = mis_q + CW'(accept & (ans1 ^ ans2));

  // Flush on an empty window without a concurrent accept never produces a record.
  assign close = (state_q == COLLECT) &
                 ((accept & (samples_inc == CW'(WIN))) |
                  (flush & ((samples_q != '0) | accept)));

  always_comb begin
    state_d       = state_q;
    samples_d     = samples_q;
    ugt_d         = ugt_q;
    sgt_d         = sgt_q;
    mis_d         = mis_q;
    win_err_d     = win_err_q;
    err_sticky_d  = err_sticky_q;
    out_samples_d = out_samples_q;
    out_ugt_d     = out_ugt_q;
    out_sgt_d     = out_sgt_q;
    out_mis_d     = out_mis_q;
    out_err_d     = out_err_q;

    case (state_q)
      COLLECT: begin
        samples_d    = samples_inc;
        ugt_d        = ugt_inc;
        sgt_d        = sgt_inc;
        mis_d        = mis_inc;
        win_err_d    = win_err_q | chk_err;
        err_sticky_d = err_sticky_q | chk_err;
        if (close) begin
          out_samples_d = samples_inc;
          out_ugt_d     = ugt_inc;
          out_sgt_d     = sgt_inc;
          out_mis_d     = mis_inc;
          out_err_d     = win_err_q | chk_err;
          state_d       = REPORT;
        end
      end
      REPORT: begin
        if (out_valid_q & out_ready) begin
          samples_d = '0;
          ugt_d     = '0;
          sgt_d     = '0;
          mis_d     = '0;
          win_err_d = 1'b0;
          state_d   = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase

    in_ready_d  = (state_d == COLLECT);
    out_valid_d = (state_d == REPORT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= COLLECT;
      in_ready_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      samples_q     <= '0;
      ugt_q         <= '0;
      sgt_q         <= '0;
      mis_q         <= '0;
      win_err_q     <= 1'b0;
      err_sticky_q  <= 1'b0;
      out_samples_q <= '0;
      out_ugt_q     <= '0;
      out_sgt_q     <= '0;
      out_mis_q     <= '0;
      out_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
      samples_q     <= samples_d;
      ugt_q         <= ugt_d;
      sgt_q         <= sgt_d;
      mis_q         <= mis_d;
      win_err_q     <= win_err_d;
      err_sticky_q  <= err_sticky_d;
      out_samples_q <= out_samples_d;
      out_ugt_q     <= out_ugt_d;
      out_sgt_q     <= out_sgt_d;
      out_mis_q     <= out_mis_d;
      out_err_q     <= out_err_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_samples = out_samples_q;
  assign out_ugt_cnt = out_ugt_q;
  assign out_sgt_cnt = out_sgt_q;
  assign out_mis_cnt = out_mis_q;
  assign out_err     = out_err_q;
  assign err_sticky  = err_sticky_q;

endmodule

// File: doc/cmp_window_stats.md
Name: cmp_window_stats

Overview:
- Downstream consumer of the 4-bit unsigned/signed comparator stage.
- Accepts a stream of operand pairs (a, b) together with the comparator's two result bits over a valid/ready handshake.
- Accumulates per-window statistics and checks each result against an internal golden compare.
- Emits one summary record per window over a second valid/ready handshake.

Parameters:
- WIN, 8, samples per window; legal range 1..255.
- CW, 8, width of each count field; must satisfy 2^CW > WIN.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high
- in_valid  input  1  operand pair and results present
- in_ready  output  1  block can accept a sample
- a  input  4  operand a as fed to comparator
- b  input  4  operand b as fed to comparator
- ans1  input  1  comparator unsigned result (a > b)
- ans2  input  1  comparator signed result ($signed(a) > $signed(b))
- flush  input  1  close the current window early
- out_valid  output  1  summary record valid
- out_ready  input  1  consumer accepts summary
- out_samples  output  CW  samples in this window
- out_ugt_cnt  output  CW  count of ans1=1
- out_sgt_cnt  output  CW  count of ans2=1
- out_mis_cnt  output  CW  count of ans1!=ans2 (sign-disagreement cases)
- out_err  output  1  at least one result in the window disagreed with the golden compare
- err_sticky  output  1  any check error since reset

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- On reset, all of the following are 0:
  - in_ready, out_valid, every out_* field, err_sticky;
  - internal counters.
  - State becomes COLLECT; in_ready rises on the first cycle after reset deasserts.
- FSM has two states, COLLECT and REPORT.
- COLLECT:
  - in_ready=1, out_valid=0.
  - Accept occurs when in_valid & in_ready.
  - Per accept:
    - samples+=1;
    - ugt+=ans1;
    - sgt+=ans2;
    - mis+=(ans1^ans2);
    - golden_u = a > b unsigned; golden_s = a > b two's complement;
    - if ans1!=golden_u or ans2!=golden_s, set win_err and err_sticky.
  - Close condition: the accept that makes samples==WIN, or flush=1 with (samples>0 or an accept this cycle).
  - On close:
    - latch the updated counts, including the current accepted sample, into out_* registers;
    - go to REPORT;
    - out_valid=1 the next cycle.
  - Latency: 1 cycle from the closing accept/flush to out_valid.
  - flush with samples==0 and no accept is ignored; no empty records are produced.
- REPORT:
  - in_ready=0; inputs are ignored, flush included.
  - out_* and out_valid are held stable until out_ready=1.
  - On the handshake:
    - clear counters and win_err;
    - go to COLLECT;
    - next cycle out_valid=0, in_ready=1.
  - out_* retain their last values after the handshake (don't-care to consumer).
  - out_ready while out_valid=0 has no effect.
- Arithmetic: counts never exceed WIN, so no wrap is possible given the CW rule.
  - golden_s is computed by sign-extending to 5 bits or by equivalent logic.
- err_sticky is cleared only by reset; it is set the cycle after the offending accept.
- Reset mid-window or during REPORT discards all partial data; no record is emitted.
- No combinational path from in_valid to in_ready or from out_ready to out_valid; both readies and valids are registered state decodes.

Test Plan:
- WIN=8. Feed 8 pairs, one per cycle, all with a=4'h8, b=4'h7, ans1=1, ans2=0.
  -> out_valid one cycle after the 8th accept; samples=8, ugt=8, sgt=0, mis=8, out_err=0.
- Feed 3 pairs (a=2,b=5,ans1=0,ans2=0), (a=4'hF,b=1,1,0), (a=3,b=4'hE,0,1); flush on the 3rd.
  -> samples=3, ugt=1, sgt=1, mis=2, out_err=0.
- Feed a=5, b=3 with ans1=0, ans2=1 (wrong unsigned result).
  -> err_sticky=1 the next cycle; that window reports out_err=1; the next window reports out_err=0 while err_sticky stays 1.
- Hold out_ready=0 for 5 cycles in REPORT with in_valid=1.
  -> in_ready=0 throughout, no counts change, out_* stable; after out_ready=1, the next window starts empty.
- Assert flush with no samples, then assert reset after 4 accepts.
  -> no record on flush; after reset, all outputs 0 and a full 8-sample window is needed for the next record.
